updown_counter_mod: RTL and testbench
=====================================

UPDOWN_COUNTER_MOD -- requirements
Module: updown_counter_mod

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..32.
REQ-002 Parameter SAT_MODE, default 0: 0 = wrap at boundaries, 1 = saturate at boundaries.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-low.
REQ-005 Port en  input  1: count enable.
REQ-006 Port updown  input  1: count direction; 1 = up, 0 = down.
REQ-007 Port load  input  1: synchronous parallel load request.
REQ-008 Port data  input  WIDTH: parallel load value.
REQ-009 Port max_val  input  WIDTH: programmable upper bound; the legal count range is 0..max_val.
REQ-010 Port data_out  output  WIDTH: registered count value.
REQ-011 Port tc  output  1: terminal-count flag, combinational.
REQ-012 Port ovf  output  1: registered boundary-event pulse.

Function
REQ-013 Priority per clock edge SHALL be: load > en > hold.
REQ-014 Load: data_out SHALL become min(data, max_val) on the next edge, regardless of en or updown.
REQ-015 Load SHALL clear ovf.
REQ-016 Up count, en=1, load=0, data_out<max_val: data_out SHALL increment by 1.
REQ-017 Down count, en=1, load=0, data_out>0: data_out SHALL decrement by 1.
REQ-018 Up-count boundary (data_out>=max_val, updown=1, en=1): next value SHALL be 0 when SAT_MODE=0, or max_val when SAT_MODE=1.
REQ-019 Down-count boundary (data_out==0, updown=0, en=1): next value SHALL be max_val when SAT_MODE=0, or 0 when SAT_MODE=1.
REQ-020 ovf SHALL be 1 for exactly the one cycle following any boundary step (REQ-018 or REQ-019) in either mode, and 0 otherwise.
REQ-021 Back-to-back boundary steps (e.g. max_val=0, or saturation held) SHALL keep ovf high on every such cycle.
REQ-022 tc SHALL be 1 when either: updown=1 and data_out>=max_val; or updown=0 and data_out==0. It is independent of en and load.
REQ-023 en=0 and load=0: data_out and direction state SHALL hold, and ovf SHALL be 0 on the next cycle.
REQ-024 A change of max_val below the current count SHALL NOT alter data_out until the next enabled or load step; at that step REQ-014, REQ-017 and REQ-018 apply.
REQ-025 max_val=0: counter SHALL stay at 0 and every enabled step SHALL be a boundary step.
REQ-026 All arithmetic SHALL be unsigned, modulo 2^WIDTH; no intermediate value wider than WIDTH+1 bits is needed.
REQ-027 Latency: data_out and ovf reflect inputs sampled at edge N on output after edge N (one cycle).

Reset
REQ-028 rst low SHALL immediately, without waiting for a clock edge, force data_out=0 and ovf=0.
REQ-029 rst asserted mid-count SHALL discard any pending load or step in that cycle.
REQ-030 After rst deasserts, the first state update SHALL occur on the first rising clk edge with rst high.
REQ-031 tc after reset SHALL follow REQ-022 with data_out=0.

Structure
REQ-032 Shared package counter_pkg SHALL hold the mode constants MODE_WRAP=0 and MODE_SAT=1, plus the default WIDTH constant.
REQ-033 No sub-module is required; next-value logic and output registers SHALL live in a single module.

Verification (WIDTH=4)
REQ-034 Reset then load data=12, max_val=15 -> data_out=12; then en=1, updown=1 for 4 cycles -> 13, 14, 15, 0, with ovf high for one cycle after the 15->0 step (SAT_MODE=0).
REQ-035 SAT_MODE=1, max_val=9, count=9, en=1, updown=1 for 3 cycles -> data_out stays 9, ovf high all 3 cycles, tc=1.
REQ-036 SAT_MODE=0, max_val=9, count=0, updown=0, en=1 -> data_out=9 with ovf pulse; next cycle -> 8, ovf=0.
REQ-037 Load data=14 with max_val=10 -> data_out=10; load and en both high with updown=0 -> load wins.
REQ-038 Count at 7, lower max_val to 5, en=1, updown=1 -> data_out=0 (wrap) with ovf; repeat in saturate mode -> data_out=5.
REQ-039 rst pulsed low between clock edges while counting -> data_out=0 and ovf=0 immediately; counting resumes from 0 at the first edge after release.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: mode constants and default width shared by the counter block
package counter_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
  localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: loadable up/down counter bounded to 0..max_val, wrapping or saturating, with registered data_out/ovf and combinational tc
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SAT_MODE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             updown,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic SAT = SAT_MODE == MODE_SAT;
  logic bnd;
  logic [WIDTH-1:0] nxt;
  assign tc = updown ? data_out >= max_val : data_out == '0;
  assign bnd = en & tc;
  always_comb begin
    nxt = load ? (data > max_val ? max_val : data)
        : !en ? data_out
        : bnd ? ((updown ^ SAT) ? '0 : max_val)
        : updown ? data_out + ONE : data_out - ONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
      ovf <= 1'b0;
    end else begin
      data_out <= nxt;
      ovf <= !load & bnd;
    end
  end
endmodule

// File: tb/tb_updown_counter_mod.sv
// tb_updown_counter_mod: checks wrap and saturate instances against an integer model plus hand-computed expectations
module tb_updown_counter_mod;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic updown = 1'b0;
  logic load = 1'b0;
  logic [3:0] data = '0;
  logic [3:0] max_val = 4'd15;
  logic [3:0] dw, ds;
  logic tcw, tcs, ow, os;
  int checks = 0;
  int errors = 0;
  int mw = 0;
  int ms = 0;
  bit mow = 0;
  bit mos = 0;
  always #5 clk = ~clk;
  updown_counter_mod #(.WIDTH(4), .SAT_MODE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .updown(updown), .load(load),
    .data(data), .max_val(max_val), .data_out(dw), .tc(tcw), .ovf(ow)
  );
  updown_counter_mod #(.WIDTH(4), .SAT_MODE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .updown(updown), .load(load),
    .data(data), .max_val(max_val), .data_out(ds), .tc(tcs), .ovf(os)
  );
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model_step(inout int m, inout bit o, input bit sat);
    int mx;
    mx = int'(max_val);
    if (load) begin
      m = int'(data) < mx ? int'(data) : mx;
      o = 0;
    end else if (!en) begin
      o = 0;
    end else if (updown) begin
      o = m >= mx;
      m = m >= mx ? (sat ? mx : 0) : m + 1;
    end else begin
      o = m == 0;
      m = m == 0 ? (sat ? 0 : mx) : m - 1;
    end
  endfunction
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mw = 0;
      ms = 0;
      mow = 0;
      mos = 0;
    end else begin
      model_step(mw, mow, 1'b0);
      model_step(ms, mos, 1'b1);
    end
  end
  always @(negedge clk) begin
    check("wrap data_out", int'(dw), mw);
    check("wrap ovf", int'(ow), int'(mow));
    check("wrap tc", int'(tcw), int'(updown ? mw >= int'(max_val) : mw == 0));
    check("sat data_out", int'(ds), ms);
    check("sat ovf", int'(os), int'(mos));
    check("sat tc", int'(tcs), int'(updown ? ms >= int'(max_val) : ms == 0));
  end
  task automatic drive(input logic e, u, l, input logic [3:0] d, m);
    en = e;
    updown = u;
    load = l;
    data = d;
    max_val = m;
    @(posedge clk);
    #2;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("reset data_out", int'(dw), 0);
    check("reset ovf", int'(ow), 0);
    check("reset tc", int'(tcw), 1);
    rst = 1'b1;
    drive(0, 1, 1, 4'd12, 4'd15);
    check("load 12", int'(dw), 12);
    drive(1, 1, 0, 4'd0, 4'd15);
    check("up 13", int'(dw), 13);
    drive(1, 1, 0, 4'd0, 4'd15);
    check("up 14", int'(dw), 14);
    drive(1, 1, 0, 4'd0, 4'd15);
    check("up 15", int'(dw), 15);
    check("tc at 15", int'(tcw), 1);
    check("no ovf at 15", int'(ow), 0);
    drive(1, 1, 0, 4'd0, 4'd15);
    check("wrap to 0", int'(dw), 0);
    check("wrap ovf", int'(ow), 1);
    check("sat held 15", int'(ds), 15);
    drive(0, 1, 1, 4'd9, 4'd9);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 4'd0, 4'd9);
      check("sat stays 9", int'(ds), 9);
      check("sat ovf held", int'(os), 1);
      check("sat tc", int'(tcs), 1);
    end
    check("wrap after 9 runs", int'(dw), 2);
    drive(0, 0, 1, 4'd0, 4'd9);
    drive(1, 0, 0, 4'd0, 4'd9);
    check("down wrap to 9", int'(dw), 9);
    check("down wrap ovf", int'(ow), 1);
    check("down sat at 0", int'(ds), 0);
    drive(1, 0, 0, 4'd0, 4'd9);
    check("down to 8", int'(dw), 8);
    check("ovf cleared", int'(ow), 0);
    check("down sat ovf held", int'(os), 1);
    drive(0, 0, 1, 4'd14, 4'd10);
    check("load clamp", int'(dw), 10);
    drive(1, 0, 1, 4'd3, 4'd10);
    check("load beats en", int'(dw), 3);
    check("load ovf", int'(ow), 0);
    drive(0, 1, 1, 4'd7, 4'd15);
    drive(0, 1, 0, 4'd0, 4'd5);
    check("hold after max drop", int'(dw), 7);
    check("tc above max", int'(tcw), 1);
    drive(1, 1, 0, 4'd0, 4'd5);
    check("wrap above max", int'(dw), 0);
    check("wrap above max ovf", int'(ow), 1);
    check("sat above max", int'(ds), 5);
    drive(0, 1, 0, 4'd0, 4'd5);
    check("hold ovf", int'(ow), 0);
    drive(0, 1, 1, 4'd3, 4'd0);
    check("max 0 load", int'(dw), 0);
    drive(1, 1, 0, 4'd0, 4'd0);
    drive(1, 1, 0, 4'd0, 4'd0);
    check("max 0 up", int'(dw), 0);
    check("max 0 ovf", int'(ow), 1);
    drive(1, 0, 0, 4'd0, 4'd0);
    check("max 0 down ovf", int'(ow), 1);
    drive(0, 1, 1, 4'd4, 4'd15);
    drive(1, 1, 0, 4'd0, 4'd15);
    check("count 5", int'(dw), 5);
    #1 rst = 1'b0;
    #1;
    check("async reset data", int'(dw), 0);
    check("async reset ovf", int'(ow), 0);
    @(posedge clk);
    #2;
    check("reset held", int'(dw), 0);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("resume from 0", int'(dw), 1);
    for (int i = 0; i < 40; i++)
      drive(i % 3 != 0, ((i / 7) % 2) == 1, i % 11 == 5, 4'(i % 16), 4'd6);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
